ifetch_sequencer: RTL
=====================

Name: ifetch_sequencer

Overview:
- Sequences the byte-wide (8-bit, big-endian) instruction memory to fetch one 32-bit instruction per PC.
- Issues four consecutive byte reads and assembles the word, then presents it to decode with a valid/ready handshake.
- Owns the architectural fetch PC: sequential increment, plus jump/branch redirect with abort of any in-flight fetch.
- Sits between the PC/branch logic and the instruction memory; decode consumes ins_word/ins_pc.

Parameters:
- ADDR_W, 8, instruction memory byte-address width (depth 2^ADDR_W = 256).
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_en  input  1  1 = fetching allowed; 0 = stop after the current word is consumed.
- redirect_valid  input  1  single-cycle jump/branch request.
- redirect_pc  input  32  target PC; bits [1:0] ignored.
- mem_rd_en  output  1  byte read strobe to the instruction memory.
- mem_addr  output  ADDR_W  byte address = low ADDR_W bits of (pc + k).
- mem_rdata  input  8  read byte, valid exactly one cycle after mem_rd_en.
- ins_valid  output  1  ins_word/ins_pc are valid.
- ins_ready  input  1  decode accepts the word.
- ins_word  output  32  assembled instruction: byte0 → [31:24] … byte3 → [7:0].
- ins_pc  output  32  PC of ins_word.
- align_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0.
- fetch_count  output  16  number of words handed to decode; wraps at 2^16.

Behaviour:
- Reset (async): state = IDLE, pc = RESET_PC, mem_rd_en = 0, mem_addr = 0, ins_valid = 0, ins_word = 0, ins_pc = 0, align_err = 0, fetch_count = 0, capture pipeline cleared. Reset asserted mid-fetch discards everything.
- States:
  - IDLE: if fetch_en, go to ISSUE (k = 0).
  - ISSUE: mem_rd_en = 1, mem_addr = pc + k for k = 0..3, one byte per cycle. After k = 3, go to DRAIN.
  - DRAIN: capture the last byte. ins_valid is set at this edge; go to HOLD.
  - HOLD: hold ins_word/ins_pc stable while ins_valid && !ins_ready.
- Byte capture: a 1-bit tag plus 2-bit index pipeline follows each read. The byte returned in cycle t+1 is written into the slot selected by the index issued at t, only if its tag is still live.
- Latency: first mem_rd_en in cycle T → ins_valid = 1 in cycle T+5.
- Handshake: a transfer occurs on an edge with ins_valid && ins_ready. At that edge:
  - ins_valid → 0, pc → pc + 4 (32-bit wrap), fetch_count + 1.
  - Next state is ISSUE if fetch_en, else IDLE.
  - Steady-state throughput with ready held high: one word per 6 cycles.
  - ins_ready while ins_valid = 0 is ignored.
- Address wrap: mem_addr uses only the low ADDR_W bits, so pc + k wraps modulo 2^ADDR_W. ins_pc carries the full 32-bit PC.
- Redirect (highest priority, any state):
  - On the edge: pc ← {redirect_pc[31:2], 2'b00}; all capture tags are killed; ins_valid → 0; state → ISSUE (k = 0) if fetch_en, else IDLE.
  - A byte from an aborted read arriving the cycle after a redirect is discarded.
  - align_err = 1 for one cycle after a misaligned redirect; the redirect is still taken.
- Simultaneous redirect and handshake: the transfer counts (fetch_count + 1); pc takes the redirect, not pc + 4.
- fetch_en deasserted mid-ISSUE: the current word completes and is delivered; no new fetch starts afterwards.
- ins_word and ins_pc change only on a load into HOLD; after a transfer they keep their last value.

Test Plan:
- Bytes 00..07 = 8C,22,00,04,02,11,40,20; reset, fetch_en = 1, ins_ready = 1 → mem_addr 0,1,2,3 in cycles 1–4; ins_valid in cycle 6 with ins_word = 8C220004, ins_pc = 0; then ins_word = 02114020, ins_pc = 4; fetch_count = 2.
- ins_ready held 0 for 10 cycles after ins_valid → ins_word/ins_pc stable and no mem_rd_en during the hold; ready = 1 → single transfer, next fetch at pc = 4.
- redirect_valid with redirect_pc = 0x40 during ISSUE at k = 2 → ins_valid stays 0; the next cycle issues mem_addr 0x40; the delivered word is mem[40..43] with no stale byte from the aborted fetch.
- redirect_pc = 0x23 → align_err pulses once; the fetch starts at 0x20; ins_pc = 0x20.
- pc = 0xFC with ADDR_W = 8 → mem_addr FC,FD,FE,FF; the next fetch issues mem_addr 00 while ins_pc = 0x100.
- Reset asserted during DRAIN → ins_valid = 0 and mem_rd_en = 0 immediately (asynchronous); after release the first fetch is from RESET_PC, with fetch_count = 0.

Source files
------------

// File: rtl/ifetch_sequencer.sv
// ifetch_sequencer
//   Fetches one 32-bit big-endian instruction per PC from a byte-wide
//   instruction memory. It issues four consecutive byte reads, assembles
//   the word and hands it to decode with a valid/ready handshake. It owns
//   the fetch PC: it increments sequentially and takes jump/branch redirects,
//   which abort any fetch in flight.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   fetch_en          1 = fetching allowed; 0 = stop once the current word is consumed
//   redirect_valid    single-cycle jump/branch request
//   redirect_pc       jump/branch target (bits [1:0] ignored)
//   mem_rd_en         byte read strobe to the instruction memory
//   mem_addr          byte address, the low ADDR_W bits of pc + k
//   mem_rdata         read byte, valid one cycle after mem_rd_en
//   ins_valid         ins_word/ins_pc are valid
//   ins_ready         decode accepts the word
//   ins_word, ins_pc  assembled instruction and its PC
//   align_err         one-cycle pulse after a misaligned redirect
//   fetch_count       number of words handed to decode (wraps at 2^16)
//
// Handshake: a word transfers on every rising edge where ins_valid && ins_ready.
// ins_word/ins_pc stay stable while ins_valid is high and ins_ready is low.
// ins_ready is ignored while ins_valid is low.

module ifetch_sequencer #(
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic [31:0]       ins_word,
   output logic [31:0]       ins_pc,
   output logic              align_err,
   output logic [15:0]       fetch_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  k, k_nxt;
   logic [31:0] pc, pc_nxt;

   // Capture pipeline: each read carries a live tag and a byte-slot index
   // for one cycle, to meet its returning byte.
   logic        cap_live;
   logic [1:0]  cap_idx;
   logic [31:0] asm_buf, asm_nxt;

   logic        transfer;

   assign transfer  = ins_valid && ins_ready;
   assign ins_valid = (state == HOLD);
   assign mem_rd_en = (state == ISSUE);
   assign mem_addr  = (state == ISSUE) ? (pc[ADDR_W-1:0] + ADDR_W'(k)) : '0;

   // Next state, PC and byte counter
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      pc_nxt    = pc;
      case (state)
         IDLE: begin
            if (fetch_en) begin
               state_nxt = ISSUE;
               k_nxt     = 2'd0;
            end
         end
         ISSUE: begin
            k_nxt = k + 2'd1;
            if (k == 2'd3) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = HOLD;
         HOLD: begin
            if (transfer) begin
               pc_nxt    = pc + 32'd4;
               state_nxt = fetch_en ? ISSUE : IDLE;
               k_nxt     = 2'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A redirect overrides everything, including the pc + 4 of a
      // simultaneous transfer.
      if (redirect_valid) begin
         pc_nxt    = {redirect_pc[31:2], 2'b00};
         state_nxt = fetch_en ? ISSUE : IDLE;
         k_nxt     = 2'd0;
      end
   end

   // Drop the returning byte into its big-endian slot (slot 0 -> [31:24]).
   always_comb begin
      asm_nxt = asm_buf;
      if (cap_live) begin
         case (cap_idx)
            2'd0:    asm_nxt[31:24] = mem_rdata;
            2'd1:    asm_nxt[23:16] = mem_rdata;
            2'd2:    asm_nxt[15:8]  = mem_rdata;
            default: asm_nxt[7:0]   = mem_rdata;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         k           <= 2'd0;
         pc          <= RESET_PC;
         cap_live    <= 1'b0;
         cap_idx     <= 2'd0;
         asm_buf     <= 32'd0;
         ins_word    <= 32'd0;
         ins_pc      <= 32'd0;
         align_err   <= 1'b0;
         fetch_count <= 16'd0;
      end else begin
         state     <= state_nxt;
         k         <= k_nxt;
         pc        <= pc_nxt;
         // A redirect kills the tag of the read issued in the same cycle,
         // so its byte is dropped when it returns.
         cap_live  <= mem_rd_en && !redirect_valid;
         cap_idx   <= k;
         asm_buf   <= asm_nxt;
         align_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (transfer) fetch_count <= fetch_count + 16'd1;
         // The word becomes visible only on the load into HOLD; the last
         // byte arrives in the same cycle, so use the merged value.
         if (state == DRAIN && !redirect_valid) begin
            ins_word <= asm_nxt;
            ins_pc   <= pc;
         end
      end
   end

endmodule
